dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-index controller: manual stepping, sawtooth / ping-pong sweep,
// and waveform selection. Phase increment and displayed Hz track the index.
module dds_sweep_ctrl #(
    parameter logic [23:0] F_STEP  = 24'h369d,
    parameter int unsigned HZ_STEP = 100000,
    parameter int unsigned IDX_MIN = 1,
    parameter int unsigned IDX_MAX = 100,
    parameter int unsigned IDX_RST = 10,
    parameter int unsigned DWELL   = 1200000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        O_pulse,
    input  logic        L_pulse,
    input  logic        R_pulse,
    input  logic        S_pulse,
    input  logic        sweep_mode,
    output logic [23:0] f_inc,
    output logic [1:0]  wave,
    output logic [26:0] WaveFreq,
    output logic        sweep_on,
    output logic        step_stb
);

    localparam int unsigned IDX_W = 7;
    localparam int unsigned F_W   = 24;
    localparam int unsigned HZ_W  = 27;
    localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [IDX_W-1:0] IDX_MIN_C  = IDX_W'(IDX_MIN);
    localparam logic [IDX_W-1:0] IDX_MAX_C  = IDX_W'(IDX_MAX);
    localparam logic [IDX_W-1:0] IDX_RST_C  = IDX_W'(IDX_RST);
    localparam logic [F_W-1:0]   F_MIN_C    = F_W'(IDX_MIN * F_STEP);
    localparam logic [F_W-1:0]   F_RST_C    = F_W'(IDX_RST * F_STEP);
    localparam logic [HZ_W-1:0]  HZ_STEP_C  = HZ_W'(HZ_STEP);
    localparam logic [HZ_W-1:0]  HZ_MIN_C   = HZ_W'(IDX_MIN * HZ_STEP);
    localparam logic [HZ_W-1:0]  HZ_RST_C   = HZ_W'(IDX_RST * HZ_STEP);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    localparam logic [1:0] ST_MANUAL   = 2'd0;
    localparam logic [1:0] ST_SWEEP_UP = 2'd1;
    localparam logic [1:0] ST_SWEEP_DN = 2'd2;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_INC  = 2'd1;
    localparam logic [1:0] OP_DEC  = 2'd2;
    localparam logic [1:0] OP_MIN  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [F_W-1:0]   f_inc_nxt;
    logic [HZ_W-1:0]  freq_nxt;
    logic [1:0]       wave_nxt;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic [1:0]       op;
    logic             chg;
    logic             chg_q;

    // State register and all registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_MANUAL;
            idx      <= IDX_RST_C;
            f_inc    <= F_RST_C;
            WaveFreq <= HZ_RST_C;
            wave     <= 2'b00;
            sweep_on <= 1'b0;
            step_stb <= 1'b0;
            chg_q    <= 1'b0;
            dwell    <= '0;
            mode_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            f_inc    <= f_inc_nxt;
            WaveFreq <= freq_nxt;
            wave     <= wave_nxt;
            sweep_on <= (state_nxt != ST_MANUAL);
            chg_q    <= chg;
            step_stb <= chg_q;
            dwell    <= dwell_nxt;
            mode_q   <= mode_nxt;
        end
    end

    // Next-state, index operation and dwell timing
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        f_inc_nxt = f_inc;
        freq_nxt  = WaveFreq;
        dwell_nxt = dwell;
        mode_nxt  = mode_q;
        op        = OP_HOLD;
        wave_nxt  = O_pulse ? (wave + 2'd1) : wave;

        case (state)
            ST_MANUAL: begin
                dwell_nxt = '0;
                if (S_pulse) begin
                    mode_nxt  = sweep_mode;
                    op        = OP_MIN;
                    state_nxt = ST_SWEEP_UP;
                end else if (R_pulse && !L_pulse && (idx != IDX_MAX_C)) begin
                    op = OP_INC;
                end else if (L_pulse && !R_pulse && (idx != IDX_MIN_C)) begin
                    op = OP_DEC;
                end
            end
            ST_SWEEP_UP, ST_SWEEP_DN: begin
                if (S_pulse) begin
                    state_nxt = ST_MANUAL;
                    dwell_nxt = '0;
                end else if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (state == ST_SWEEP_UP) begin
                        if (idx != IDX_MAX_C) begin
                            op = OP_INC;
                        end else if (mode_q) begin
                            op        = OP_DEC;
                            state_nxt = ST_SWEEP_DN;
                        end else begin
                            op = OP_MIN;
                        end
                    end else begin
                        if (idx != IDX_MIN_C) begin
                            op = OP_DEC;
                        end else begin
                            op        = OP_INC;
                            state_nxt = ST_SWEEP_UP;
                        end
                    end
                end else begin
                    dwell_nxt = dwell + DW_W'(1);
                end
            end
            default: begin
                state_nxt = ST_MANUAL;
                dwell_nxt = '0;
            end
        endcase

        // Outputs follow the index incrementally, no multipliers
        case (op)
            OP_INC: begin
                idx_nxt   = idx + IDX_W'(1);
                f_inc_nxt = f_inc + F_STEP;
                freq_nxt  = WaveFreq + HZ_STEP_C;
            end
            OP_DEC: begin
                idx_nxt   = idx - IDX_W'(1);
                f_inc_nxt = f_inc - F_STEP;
                freq_nxt  = WaveFreq - HZ_STEP_C;
            end
            OP_MIN: begin
                idx_nxt   = IDX_MIN_C;
                f_inc_nxt = F_MIN_C;
                freq_nxt  = HZ_MIN_C;
            end
            default: ;
        endcase

        chg = (idx_nxt != idx);
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed manual/sweep/reset steps plus random
// pulses, every cycle compared against an arithmetic reference model.
module tb_dds_sweep_ctrl;

    localparam logic [23:0] F_STEP_TB  = 24'h369d;
    localparam int          HZ_TB      = 100000;
    localparam int          IDX_MIN_TB = 1;
    localparam int          IDX_MAX_TB = 100;
    localparam int          IDX_RST_TB = 10;
    localparam int          DWELL_TB   = 4;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        O_pulse = 1'b0;
    logic        L_pulse = 1'b0;
    logic        R_pulse = 1'b0;
    logic        S_pulse = 1'b0;
    logic        sweep_mode = 1'b0;
    logic [23:0] f_inc;
    logic [1:0]  wave;
    logic [26:0] WaveFreq;
    logic        sweep_on;
    logic        step_stb;

    always #5 clk_in = ~clk_in;

    dds_sweep_ctrl #(
        .F_STEP  (F_STEP_TB),
        .HZ_STEP (HZ_TB),
        .IDX_MIN (IDX_MIN_TB),
        .IDX_MAX (IDX_MAX_TB),
        .IDX_RST (IDX_RST_TB),
        .DWELL   (DWELL_TB)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .O_pulse    (O_pulse),
        .L_pulse    (L_pulse),
        .R_pulse    (R_pulse),
        .S_pulse    (S_pulse),
        .sweep_mode (sweep_mode),
        .f_inc      (f_inc),
        .wave       (wave),
        .WaveFreq   (WaveFreq),
        .sweep_on   (sweep_on),
        .step_stb   (step_stb)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;

    // Reference model: index, sweep direction, dwell position, latched mode
    int m_idx;
    int m_dwell;
    int m_wave;
    bit m_sweep;
    bit m_up;
    bit m_mode;
    bit m_chg_prev;
    bit m_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx      = IDX_RST_TB;
        m_dwell    = 0;
        m_wave     = 0;
        m_sweep    = 1'b0;
        m_up       = 1'b1;
        m_mode     = 1'b0;
        m_chg_prev = 1'b0;
        m_stb      = 1'b0;
    endtask

    task automatic model_tick(input bit o, input bit l, input bit r, input bit s, input bit md);
        int nxt;
        nxt   = m_idx;
        m_stb = m_chg_prev;
        if (o) m_wave = (m_wave + 1) % 4;
        if (!m_sweep) begin
            if (s) begin
                m_mode  = md;
                m_sweep = 1'b1;
                m_up    = 1'b1;
                m_dwell = 0;
                nxt     = IDX_MIN_TB;
            end else if (r && !l && m_idx < IDX_MAX_TB) begin
                nxt = m_idx + 1;
            end else if (l && !r && m_idx > IDX_MIN_TB) begin
                nxt = m_idx - 1;
            end
        end else if (s) begin
            m_sweep = 1'b0;
            m_dwell = 0;
        end else if (m_dwell == DWELL_TB - 1) begin
            m_dwell = 0;
            if (m_up) begin
                if (m_idx < IDX_MAX_TB) nxt = m_idx + 1;
                else if (m_mode) begin
                    nxt  = IDX_MAX_TB - 1;
                    m_up = 1'b0;
                end else nxt = IDX_MIN_TB;
            end else begin
                if (m_idx > IDX_MIN_TB) nxt = m_idx - 1;
                else begin
                    nxt  = IDX_MIN_TB + 1;
                    m_up = 1'b1;
                end
            end
        end else begin
            m_dwell++;
        end
        m_chg_prev = (nxt != m_idx);
        m_idx      = nxt;
    endtask

    task automatic check_all();
        chk("f_inc",    32'(f_inc),    32'(m_idx) * 32'(F_STEP_TB));
        chk("WaveFreq", 32'(WaveFreq), 32'(m_idx * HZ_TB));
        chk("wave",     32'(wave),     32'(m_wave));
        chk("sweep_on", 32'(sweep_on), 32'(m_sweep));
        chk("step_stb", 32'(step_stb), 32'(m_stb));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_f_inc"},    32'(f_inc),    32'h22222);
        chk({tag, "_WaveFreq"}, 32'(WaveFreq), 32'd1000000);
        chk({tag, "_wave"},     32'(wave),     32'd0);
        chk({tag, "_sweep_on"}, 32'(sweep_on), 32'd0);
        chk({tag, "_step_stb"}, 32'(step_stb), 32'd0);
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later
    task automatic step(input bit o, input bit l, input bit r, input bit s, input bit md);
        @(negedge clk_in);
        O_pulse    = o;
        L_pulse    = l;
        R_pulse    = r;
        S_pulse    = s;
        sweep_mode = md;
        @(posedge clk_in);
        model_tick(o, l, r, s, md);
        #1;
        check_all();
        if (step_stb) stb_cnt++;
        O_pulse = 1'b0;
        L_pulse = 1'b0;
        R_pulse = 1'b0;
        S_pulse = 1'b0;
    endtask

    logic [23:0] prev_f;
    bit          saw_wrap;
    bit          saw_top;
    bit          saw_bot;

    initial begin
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_vals("reset");
        @(negedge clk_in);
        rst_n = 1'b1;

        // Three step-ups from the reset index
        stb_cnt = 0;
        repeat (3) step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("r3_f_inc", 32'(f_inc), 32'(24'(13 * 24'h369d)));
        chk("r3_WaveFreq", 32'(WaveFreq), 32'd1300000);
        chk("r3_stb_count", 32'(stb_cnt), 32'd3);

        // Wave advance concurrent with step-up
        repeat (5) step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("o5_wave", 32'(wave), 32'd1);
        chk("o5_f_inc", 32'(f_inc), 32'(24'(18 * 24'h369d)));

        // Lower bound: no wrap, no strobe
        for (int k = 0; k < 200 && m_idx > IDX_MIN_TB; k++) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        stb_cnt = 0;
        step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("min_f_inc", 32'(f_inc), 32'h369d);
        chk("min_stb_count", 32'(stb_cnt), 32'd0);

        // Upper bound
        for (int k = 0; k < 200 && m_idx < IDX_MAX_TB; k++) step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        stb_cnt = 0;
        step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("max_f_inc", 32'(f_inc), 32'h155554);
        chk("max_stb_count", 32'(stb_cnt), 32'd0);

        // Simultaneous L and R
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        stb_cnt = 0;
        step(0, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("lr_f_inc", 32'(f_inc), 32'(24'(97 * 24'h369d)));
        chk("lr_stb_count", 32'(stb_cnt), 32'd0);

        // Sawtooth sweep; mode input wiggles during the sweep
        step(0, 0, 0, 1, 0);
        chk("saw_start_f_inc", 32'(f_inc), 32'h369d);
        chk("saw_start_on", 32'(sweep_on), 32'd1);
        prev_f   = f_inc;
        saw_wrap = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 0, $urandom_range(0, 1) == 1);
            if (prev_f == 24'h155554 && f_inc == 24'h369d) begin
                saw_wrap = 1'b1;
                break;
            end
            prev_f = f_inc;
        end
        chk("saw_wrap_seen", 32'(saw_wrap), 32'd1);
        chk("saw_wrap_on", 32'(sweep_on), 32'd1);
        repeat (9) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("saw_stop_on", 32'(sweep_on), 32'd0);

        // Ping-pong sweep, stopped at index 57 on the second rise
        step(0, 0, 0, 1, 1);
        prev_f  = f_inc;
        saw_top = 1'b0;
        saw_bot = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            step(0, 0, 0, 0, $urandom_range(0, 1) == 1);
            if (prev_f == 24'(100 * 24'h369d) && f_inc == 24'(99 * 24'h369d)) saw_top = 1'b1;
            if (saw_top && prev_f == 24'h369d && f_inc == 24'(2 * 24'h369d)) saw_bot = 1'b1;
            if (saw_bot && f_inc == 24'(57 * 24'h369d)) break;
            prev_f = f_inc;
        end
        chk("pp_top_seen", 32'(saw_top), 32'd1);
        chk("pp_bot_seen", 32'(saw_bot), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("pp_stop_on", 32'(sweep_on), 32'd0);
        chk("pp_stop_f_inc", 32'(f_inc), 32'(24'(57 * 24'h369d)));
        repeat (10) step(0, 0, 0, 0, 0);

        // Random pulses in all states
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a sweep
        if (!m_sweep) step(0, 0, 0, 1, 1);
        repeat (13) step(0, 0, 0, 0, 0);
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (12) step(0, 0, 0, 0, 0);
        chk("post_rst_on", 32'(sweep_on), 32'd0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
